mem_arbiter: RTL and testbench

// - Shares one byte-wide external synchronous RAM port between instruction fetch (IF) and load/store (MEM).
// - Sequences each 32-bit access as 4 byte beats.
// - Drives stall requests to ctrl until the access completes.
// - Sits between pc_reg/if_id/mem and the chip-level RAM pins.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM encoding and widths shared by the byte-serial RAM arbiter.
package mem_arbiter_pkg;
    localparam int CNT_W  = 3;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_RD_IF,
        ARB_RD_MEM,
        ARB_WR_MEM,
        ARB_DONE
    } arb_state_e;

    function automatic logic is_read(input arb_state_e s);
        return s == ARB_RD_IF || s == ARB_RD_MEM;
    endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous RAM between fetch and load/store,
// sequencing each word as NBYTES little-endian beats and stalling until done.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_req_i,
    input  logic [ADDR_W-1:0]        if_addr_i,
    input  logic                     if_flush_i,
    output logic [BYTE_W*NBYTES-1:0] if_data_o,
    output logic                     if_done_o,
    input  logic                     mem_req_i,
    input  logic                     mem_we_i,
    input  logic [NBYTES-1:0]        mem_sel_i,
    input  logic [ADDR_W-1:0]        mem_addr_i,
    input  logic [BYTE_W*NBYTES-1:0] mem_data_i,
    output logic [BYTE_W*NBYTES-1:0] mem_data_o,
    output logic                     mem_done_o,
    output logic                     stallreq_if_o,
    output logic                     stallreq_mem_o,
    output logic [ADDR_W-1:0]        ext_addr_o,
    output logic [BYTE_W-1:0]        ext_dout_o,
    output logic                     ext_we_o,
    input  logic [BYTE_W-1:0]        ext_din_i
);
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(NBYTES);
    localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(NBYTES - 1);

    arb_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic gnt_mem_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NBYTES-1:0][BYTE_W-1:0] buf_q, buf_d, wr_bytes;
    logic [BYTE_W*NBYTES-1:0] if_data_q, mem_data_q;
    logic [IDX_W-1:0] beat;
    logic rd, stay;

    assign wr_bytes   = mem_data_i;
    assign beat       = cnt_q[IDX_W-1:0];
    assign if_data_o  = if_data_q;
    assign mem_data_o = mem_data_q;
    assign ext_addr_o = addr_q;

    always_ff @(posedge clk) state_q <= !rst ? ARB_IDLE : state_d;

    // Loads/stores outrank fetch; flush only ever touches the fetch path.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:   state_d = mem_req_i ? (mem_we_i ? ARB_WR_MEM : ARB_RD_MEM)
                                : (if_req_i && !if_flush_i) ? ARB_RD_IF : ARB_IDLE;
            ARB_RD_IF:  state_d = if_flush_i ? ARB_IDLE : (cnt_q == LAST_RD) ? ARB_DONE : ARB_RD_IF;
            ARB_RD_MEM: state_d = (cnt_q == LAST_RD) ? ARB_DONE : ARB_RD_MEM;
            ARB_WR_MEM: state_d = (cnt_q == LAST_WR) ? ARB_DONE : ARB_WR_MEM;
            default:    state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        rd    = is_read(state_q);
        stay  = state_d == state_q && state_q != ARB_IDLE && state_q != ARB_DONE;
        buf_d = buf_q;
        if (rd && cnt_q != '0) buf_d[IDX_W'(cnt_q - 1'b1)] = ext_din_i;
        if_done_o      = state_q == ARB_DONE && !gnt_mem_q && !if_flush_i;
        mem_done_o     = state_q == ARB_DONE && gnt_mem_q;
        ext_we_o       = state_q == ARB_WR_MEM && mem_sel_i[beat];
        ext_dout_o     = state_q == ARB_WR_MEM ? wr_bytes[beat] : '0;
        stallreq_if_o  = if_req_i && !if_done_o && !if_flush_i;
        stallreq_mem_o = mem_req_i && !mem_done_o;
    end

    // Read data lags its address by one beat, so byte cnt-1 lands at beat cnt.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            gnt_mem_q  <= 1'b0;
            addr_q     <= '0;
            buf_q      <= '0;
            if_data_q  <= '0;
            mem_data_q <= '0;
        end else begin
            if (state_q == ARB_IDLE && state_d != ARB_IDLE) begin
                cnt_q     <= '0;
                gnt_mem_q <= mem_req_i;
                addr_q    <= mem_req_i ? mem_addr_i : if_addr_i;
            end else if (state_q != ARB_IDLE && state_q != ARB_DONE) begin
                cnt_q <= cnt_q + 1'b1;
                if (stay && cnt_q < LAST_WR) addr_q <= addr_q + ADDR_W'(1);
            end
            if (rd) buf_q <= buf_d;
            if (rd && state_d == ARB_DONE) begin
                if (gnt_mem_q) mem_data_q <= buf_d;
                else if_data_q <= buf_d;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of the arbiter and a shadow copy of RAM.
module tb_mem_arbiter;
    logic clk = 1'b0, rst = 1'b0;
    logic if_req_i = 1'b0, if_flush_i = 1'b0, mem_req_i = 1'b0, mem_we_i = 1'b0;
    logic [31:0] if_addr_i = '0, mem_addr_i = '0, mem_data_i = '0;
    logic [3:0] mem_sel_i = '0;
    logic [31:0] if_data_o, mem_data_o, ext_addr_o;
    logic if_done_o, mem_done_o, stallreq_if_o, stallreq_mem_o, ext_we_o;
    logic [7:0] ext_dout_o;
    logic [7:0] ext_din_i = '0;
    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [7:0] ram [logic [31:0]];
    logic [7:0] shadow [logic [31:0]];

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_data_o(if_data_o), .if_done_o(if_done_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_data_o(mem_data_o), .mem_done_o(mem_done_o),
        .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
        .ext_addr_o(ext_addr_o), .ext_dout_o(ext_dout_o), .ext_we_o(ext_we_o),
        .ext_din_i(ext_din_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[23:16] ^ 8'hA5;
    endfunction
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction
    function automatic logic [7:0] sh_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : dflt(a);
    endfunction

    // External synchronous RAM: data one cycle after address, write at the strobe edge.
    always @(posedge clk) ext_din_i <= ram_rd(ext_addr_o);
    always @(posedge clk) if (ext_we_o) ram[ext_addr_o] = ext_dout_o;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram[a] = d;
        shadow[a] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction model: kind 0 idle, 1 fetch, 2 load, 3 store; ph counts cycles since grant.
    int m_kind = 0, m_ph = 0;
    logic [31:0] m_base = '0, m_last = '0, m_wdata = '0;
    logic [3:0] m_sel = '0;
    bit m_on = 1'b0;

    always @(negedge clk) begin : model
        logic [31:0] e_addr, word;
        logic e_ifd, e_md, e_we;
        logic [7:0] e_do;
        int beat;
        e_addr = m_last;
        e_ifd = 1'b0;
        e_md = 1'b0;
        e_we = 1'b0;
        e_do = '0;
        beat = m_ph - 1;
        if (m_kind != 0) e_addr = m_base + 32'(m_ph <= 4 ? beat : 3);
        if ((m_kind == 1 || m_kind == 2) && m_ph == 6) begin
            e_ifd = m_kind == 1 && !if_flush_i;
            e_md = m_kind == 2;
        end
        if (m_kind == 3) begin
            if (m_ph <= 4) begin
                e_we = m_sel[beat];
                e_do = m_wdata[8*beat +: 8];
            end else e_md = 1'b1;
        end
        word = {sh_rd(m_base + 32'd3), sh_rd(m_base + 32'd2), sh_rd(m_base + 32'd1), sh_rd(m_base)};
        if (m_on) begin
            chk("if_done", {31'b0, if_done_o}, {31'b0, e_ifd});
            chk("mem_done", {31'b0, mem_done_o}, {31'b0, e_md});
            chk("ext_we", {31'b0, ext_we_o}, {31'b0, e_we});
            chk("ext_dout", {24'b0, ext_dout_o}, {24'b0, e_do});
            chk("ext_addr", ext_addr_o, e_addr);
            chk("stall_if", {31'b0, stallreq_if_o}, {31'b0, if_req_i & ~e_ifd & ~if_flush_i});
            chk("stall_mem", {31'b0, stallreq_mem_o}, {31'b0, mem_req_i & ~e_md});
            if (e_ifd) chk("if_data", if_data_o, word);
            if (e_md && m_kind == 2) chk("mem_data", mem_data_o, word);
        end
        if (e_we) shadow[e_addr] = e_do;
        if (!rst) begin
            m_kind = 0;
            m_last = '0;
        end else begin
            m_last = e_addr;
            if (m_kind == 0) begin
                m_ph = 1;
                m_base = mem_req_i ? mem_addr_i : if_addr_i;
                m_sel = mem_sel_i;
                m_wdata = mem_data_i;
                m_kind = mem_req_i ? (mem_we_i ? 3 : 2) : (if_req_i && !if_flush_i) ? 1 : 0;
            end else if ((m_kind == 1 && m_ph <= 5 && if_flush_i) || m_ph == (m_kind == 3 ? 5 : 6))
                m_kind = 0;
            else m_ph++;
        end
        m_on = 1'b1;
    end

    task automatic wait_done(input bit mem, input int t0, output int lat, output logic [31:0] data);
        lat = -1;
        data = '0;
        for (int i = 0; i < 30 && lat < 0; i++) begin
            @(negedge clk);
            if (mem ? mem_done_o : if_done_o) begin
                lat = cyc - t0;
                data = mem ? mem_data_o : if_data_o;
            end
        end
        tick();
        if (mem) mem_req_i = 1'b0;
        else if_req_i = 1'b0;
    endtask

    function automatic logic [31:0] raddr();
        case ($urandom_range(0, 2))
            0: return 32'h0000_0100 + 32'($urandom_range(0, 31));
            1: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, lat, ilat, mlat;
        logic [31:0] data, idat, mdat;
        logic [31:0] seq [4];
        logic [31:0] wrap_exp [4];
        bit seen, idn, mdn;
        wrap_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

        repeat (3) tick();
        @(negedge clk);
        chk("rst_ext_addr", ext_addr_o, 32'h0);
        chk("rst_if_data", if_data_o, 32'h0);
        chk("rst_mem_data", mem_data_o, 32'h0);
        tick();
        rst = 1'b1;

        // Fetch of a known word
        poke(32'h10, 8'h44); poke(32'h11, 8'h33); poke(32'h12, 8'h22); poke(32'h13, 8'h11);
        tick(); if_addr_i = 32'h10; if_req_i = 1'b1; t0 = cyc;
        wait_done(1'b0, t0, lat, data);
        chk("t1_lat", 32'(lat), 32'd6);
        chk("t1_data", data, 32'h1122_3344);

        // Partial store with byte enables
        poke(32'h101, 8'h77); poke(32'h103, 8'h66);
        tick(); mem_we_i = 1'b1; mem_sel_i = 4'b0101; mem_addr_i = 32'h100;
        mem_data_i = 32'hAABB_CCDD; mem_req_i = 1'b1; t0 = cyc;
        wait_done(1'b1, t0, lat, data);
        chk("t2_lat", 32'(lat), 32'd5);
        chk("t2_b0", {24'b0, ram_rd(32'h100)}, 32'hDD);
        chk("t2_b1", {24'b0, ram_rd(32'h101)}, 32'h77);
        chk("t2_b2", {24'b0, ram_rd(32'h102)}, 32'hBB);
        chk("t2_b3", {24'b0, ram_rd(32'h103)}, 32'h66);

        // Simultaneous requests: load first, fetch in the following idle
        poke(32'h200, 8'h01); poke(32'h201, 8'h02); poke(32'h202, 8'h03); poke(32'h203, 8'h04);
        tick(); mem_we_i = 1'b0; mem_addr_i = 32'h200; mem_req_i = 1'b1;
        if_addr_i = 32'h10; if_req_i = 1'b1; t0 = cyc;
        ilat = -1; mlat = -1; idat = '0; mdat = '0;
        for (int i = 0; i < 40 && (ilat < 0 || mlat < 0); i++) begin
            @(negedge clk);
            if (mem_done_o) begin mlat = cyc - t0; mdat = mem_data_o; end
            if (if_done_o) begin ilat = cyc - t0; idat = if_data_o; end
            tick();
            if (mlat >= 0) mem_req_i = 1'b0;
            if (ilat >= 0) if_req_i = 1'b0;
        end
        chk("t3_mem_lat", 32'(mlat), 32'd6);
        chk("t3_mem_data", mdat, 32'h0403_0201);
        chk("t3_if_lat", 32'(ilat), 32'd13);
        chk("t3_if_data", idat, 32'h1122_3344);

        // Flush mid-fetch, then refetch elsewhere
        poke(32'h40, 8'hEF); poke(32'h41, 8'hBE); poke(32'h42, 8'hAD); poke(32'h43, 8'hDE);
        tick(); if_addr_i = 32'h30; if_req_i = 1'b1; t0 = cyc;
        seen = 1'b0;
        repeat (3) begin @(negedge clk); seen |= if_done_o; tick(); end
        if_flush_i = 1'b1;
        @(negedge clk); seen |= if_done_o;
        chk("t4_stall_flush", {31'b0, stallreq_if_o}, 32'd0);
        tick(); if_flush_i = 1'b0; if_addr_i = 32'h40; t1 = cyc;
        wait_done(1'b0, t1, lat, data);
        chk("t4_no_done", {31'b0, seen}, 32'd0);
        chk("t4_lat", 32'(lat), 32'd6);
        chk("t4_data", data, 32'hDEAD_BEEF);

        // Address wrap
        poke(32'hFFFF_FFFE, 8'hA1); poke(32'hFFFF_FFFF, 8'hB2); poke(32'h0, 8'hC3); poke(32'h1, 8'hD4);
        tick(); mem_we_i = 1'b0; mem_addr_i = 32'hFFFF_FFFE; mem_req_i = 1'b1; t0 = cyc;
        tick();
        for (int k = 0; k < 4; k++) begin @(negedge clk); seq[k] = ext_addr_o; tick(); end
        wait_done(1'b1, t0, lat, data);
        for (int k = 0; k < 4; k++) chk("t5_addr", seq[k], wrap_exp[k]);
        chk("t5_lat", 32'(lat), 32'd6);
        chk("t5_data", data, 32'hD4C3_B2A1);

        // Reset during write beat 1
        tick(); mem_we_i = 1'b1; mem_sel_i = 4'b1111; mem_addr_i = 32'h300;
        mem_data_i = 32'h1234_5678; mem_req_i = 1'b1;
        tick(); tick();
        rst = 1'b0; mem_req_i = 1'b0;
        @(negedge clk);
        chk("t6_beat1_we", {31'b0, ext_we_o}, 32'd1);
        tick(); rst = 1'b1;
        @(negedge clk);
        chk("t6_we", {31'b0, ext_we_o}, 32'd0);
        chk("t6_done", {30'b0, if_done_o, mem_done_o}, 32'd0);
        chk("t6_addr", ext_addr_o, 32'h0);
        chk("t6_if_data", if_data_o, 32'h0);
        chk("t6_mem_data", mem_data_o, 32'h0);
        tick(); mem_we_i = 1'b0; mem_addr_i = 32'h200; mem_req_i = 1'b1; t0 = cyc;
        wait_done(1'b1, t0, lat, data);
        chk("t6_clean_lat", 32'(lat), 32'd6);
        chk("t6_clean_data", data, 32'h0403_0201);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            idn = if_done_o;
            mdn = mem_done_o;
            tick();
            if (if_flush_i) begin if_flush_i = 1'b0; if_addr_i = raddr(); end
            if (idn) if_req_i = 1'b0;
            if (mdn) mem_req_i = 1'b0;
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 999) == 0) begin
                rst = 1'b0; if_req_i = 1'b0; mem_req_i = 1'b0;
            end
            if (!if_req_i && $urandom_range(0, 2) == 0) begin
                if_req_i = 1'b1; if_addr_i = raddr();
            end
            if (!mem_req_i && $urandom_range(0, 3) == 0) begin
                mem_req_i = 1'b1; mem_we_i = 1'($urandom); mem_sel_i = 4'($urandom);
                mem_addr_i = raddr(); mem_data_i = $urandom;
            end
            if (if_req_i && $urandom_range(0, 19) == 0) if_flush_i = 1'b1;
        end
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
